// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/stop sequencer.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_UP_ZERO   = 2'b00,
    MODE_UP_PRESET = 2'b01,
    MODE_DN_MAX    = 2'b10,
    MODE_DN_PRESET = 2'b11
  } mode_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;
  localparam logic [15:0] BCD_MIN = 16'h0000;

  // Out-of-range switch settings saturate at the largest BCD digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [15:0] preset_value(input logic [3:0] msb, input logic [3:0] lsb);
    return {bcd_clamp(msb), bcd_clamp(lsb), 8'h00};
  endfunction

endpackage

// File: rtl/stopwatch_run_ctrl_if.sv
// Board-side inputs and counter-datapath controls of the run/stop sequencer.
interface stopwatch_run_ctrl_if;

  logic        b;
  logic [1:0]  mode;
  logic [3:0]  MSB;
  logic [3:0]  LSB;
  logic        cnt_at_lim;
  logic        cnt_load;
  logic [15:0] load_value;
  logic        cnt_en;
  logic        cnt_up;
  logic        running;
  logic        done;

  modport master (
    input  b, mode, MSB, LSB, cnt_at_lim,
    output cnt_load, load_value, cnt_en, cnt_up, running, done
  );

  modport slave (
    output b, mode, MSB, LSB, cnt_at_lim,
    input  cnt_load, load_value, cnt_en, cnt_up, running, done
  );

endinterface

// File: rtl/btn_conditioner.sv
// Pushbutton conditioning: 2-flop synchronizer, level debounce, one-cycle press pulse.
module btn_conditioner #(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic b,
  output logic press
);

  localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync_p0 <= b;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Any sample that agrees with the accepted level restarts the stability count.
      if (sync_p1 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DB_LAST) begin
        stable_cnt <= '0;
        level      <= sync_p1;
        press      <= sync_p1;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Run/stop sequencer for the 4-digit BCD stopwatch: mode capture, load-value select,
// 10 ms tick prescaler and the LOAD/IDLE/RUN/PAUSE/DONE control FSM.
module stopwatch_run_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 1_000_000,
  parameter int DB_CYCLES = 500_000
) (
  input  logic                 clk,
  input  logic                 reset,
  stopwatch_run_ctrl_if.master sw
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  mode_t         mode_q;
  logic          mode_chg;
  logic          press;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [15:0]   load_sel;

  logic          cnt_load_q, cnt_load_d;
  logic [15:0]   load_value_q, load_value_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_up_q, cnt_up_d;
  logic          running_q;
  logic          done_q;

  btn_conditioner #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn (
    .clk   (clk),
    .reset (reset),
    .b     (sw.b),
    .press (press)
  );

  assign mode_chg = (sw.mode != mode_q);
  assign tick     = (presc_q == TICK_LAST);

  always_comb begin
    load_sel = BCD_MIN;
    case (mode_q)
      MODE_UP_ZERO: load_sel = BCD_MIN;
      MODE_DN_MAX:  load_sel = BCD_MAX;
      default:      load_sel = preset_value(sw.MSB, sw.LSB);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    cnt_load_d   = 1'b0;
    cnt_en_d     = 1'b0;
    cnt_up_d     = cnt_up_q;
    load_value_d = load_value_q;
    unique case (state_q)
      ST_LOAD: begin
        cnt_load_d   = 1'b1;
        load_value_d = load_sel;
        cnt_up_d     = ~mode_q[1];
        state_d      = ST_IDLE;
      end
      ST_IDLE: begin
        if (mode_chg) begin
          state_d = ST_LOAD;
        end else if (press) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        // Mode changes are deliberately ignored here so direction cannot flip mid-count.
        presc_d  = tick ? '0 : presc_q + 1'b1;
        cnt_en_d = tick & ~sw.cnt_at_lim;
        if (sw.cnt_at_lim) begin
          state_d = ST_DONE;
        end else if (press) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        presc_d = '0;
        if (mode_chg) begin
          state_d = ST_LOAD;
        end else if (press) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (press || mode_chg) begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Register stage: every output is driven straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      mode_q       <= MODE_UP_ZERO;
      presc_q      <= '0;
      cnt_load_q   <= 1'b0;
      load_value_q <= BCD_MIN;
      cnt_en_q     <= 1'b0;
      cnt_up_q     <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_t'(sw.mode);
      presc_q      <= presc_d;
      cnt_load_q   <= cnt_load_d;
      load_value_q <= load_value_d;
      cnt_en_q     <= cnt_en_d;
      cnt_up_q     <= cnt_up_d;
      running_q    <= (state_d == ST_RUN);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign sw.cnt_load   = cnt_load_q;
  assign sw.load_value = load_value_q;
  assign sw.cnt_en     = cnt_en_q;
  assign sw.cnt_up     = cnt_up_q;
  assign sw.running    = running_q;
  assign sw.done       = done_q;

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Testbench for stopwatch_run_ctrl: directed scenarios plus random stimulus, all outputs
// compared every cycle against a cycle-level behavioural model.
module tb_stopwatch_run_ctrl;

  localparam int TD = 4;
  localparam int DB = 2;
  localparam int P_LOAD = 0, P_IDLE = 1, P_RUN = 2, P_PAUSE = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic reset;

  stopwatch_run_ctrl_if sw ();

  stopwatch_run_ctrl #(
    .TICK_DIV  (TD),
    .DB_CYCLES (DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  int         ph;
  int         age;
  bit         m_press;
  bit         m_lvl;
  bit         raw_q[$];
  bit         win[$];
  logic [1:0] m_mq;
  logic       e_load, e_en, e_up, e_run, e_done;
  logic [15:0] e_lv;

  int          load_cnt = 0;
  int          en_cnt   = 0;
  logic [15:0] last_lv  = 16'h0;
  int          lc, ec, hold;

  function automatic logic [15:0] exp_load(logic [1:0] m, logic [3:0] hi, logic [3:0] lo);
    int h, l;
    h = (hi > 9) ? 9 : int'(hi);
    l = (lo > 9) ? 9 : int'(lo);
    case (m)
      2'd0:    return 16'h0000;
      2'd2:    return 16'h9999;
      default: return 16'(h * 4096 + l * 256);
    endcase
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_LOAD; age = 0; m_press = 0; m_lvl = 0; m_mq = 2'd0;
    raw_q.delete(); raw_q.push_back(1'b0); raw_q.push_back(1'b0);
    win.delete();
    e_load = 0; e_en = 0; e_up = 1; e_run = 0; e_done = 0; e_lv = 16'h0;
  endtask

  // One rising edge of the reference: button path first, then the control decision
  // made with the press that was visible before this edge.
  task automatic model_edge();
    bit p_old, s, flip, chg;
    p_old = m_press;
    raw_q.push_back(sw.b);
    s = raw_q.pop_front();
    win.push_back(s);
    if (win.size() > DB) void'(win.pop_front());
    flip = (win.size() == DB);
    foreach (win[i]) if (win[i] == m_lvl) flip = 0;
    m_press = 0;
    if (flip) begin
      m_lvl = ~m_lvl;
      m_press = m_lvl;
      win.delete();
    end
    chg = (sw.mode != m_mq);
    e_load = 0;
    e_en = 0;
    case (ph)
      P_LOAD: begin
        e_load = 1;
        e_lv = exp_load(m_mq, sw.MSB, sw.LSB);
        e_up = (m_mq < 2'd2);
        ph = P_IDLE;
      end
      P_IDLE: begin
        if (chg) ph = P_LOAD;
        else if (p_old) begin ph = P_RUN; age = 0; end
      end
      P_RUN: begin
        if (sw.cnt_at_lim) ph = P_DONE;
        else begin
          if (age % TD == TD - 1) e_en = 1;
          if (p_old) ph = P_PAUSE;
        end
        age++;
      end
      P_PAUSE: begin
        if (chg) ph = P_LOAD;
        else if (p_old) begin ph = P_RUN; age = 0; end
      end
      default: begin
        if (p_old || chg) ph = P_LOAD;
      end
    endcase
    m_mq = sw.mode;
    e_run = (ph == P_RUN);
    e_done = (ph == P_DONE);
  endtask

  task automatic check_all();
    chk("cnt_load",   16'(sw.cnt_load), 16'(e_load));
    chk("load_value", sw.load_value, e_lv);
    chk("cnt_en",     16'(sw.cnt_en), 16'(e_en));
    chk("cnt_up",     16'(sw.cnt_up), 16'(e_up));
    chk("running",    16'(sw.running), 16'(e_run));
    chk("done",       16'(sw.done), 16'(e_done));
    chk("load_en_exclusive", 16'(sw.cnt_load & sw.cnt_en), 16'h0);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_cnt_load"},   16'(sw.cnt_load), 16'h0);
    chk({tag, "_load_value"}, sw.load_value, 16'h0000);
    chk({tag, "_cnt_en"},     16'(sw.cnt_en), 16'h0);
    chk({tag, "_cnt_up"},     16'(sw.cnt_up), 16'h1);
    chk({tag, "_running"},    16'(sw.running), 16'h0);
    chk({tag, "_done"},       16'(sw.done), 16'h0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (sw.cnt_load) begin load_cnt++; last_lv = sw.load_value; end
    if (sw.cnt_en) en_cnt++;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic press_btn();
    sw.b = 1'b1;
    run(4);
    sw.b = 1'b0;
    run(4);
  endtask

  initial begin
    reset = 1'b0;
    sw.b = 1'b0; sw.mode = 2'd0; sw.MSB = 4'd0; sw.LSB = 4'd0; sw.cnt_at_lim = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk_reset_vals("reset");
    reset = 1'b1;

    // Power-up load with mode 00
    run(3);
    chk("boot_loads", 16'(load_cnt), 16'd1);
    chk("boot_value", last_lv, 16'h0000);

    // Preset 37 counting up
    sw.mode = 2'd1; sw.MSB = 4'd3; sw.LSB = 4'd7;
    lc = load_cnt; run(3);
    chk("m01_loads", 16'(load_cnt - lc), 16'd1);
    chk("m01_value", last_lv, 16'h3700);
    press_btn();
    ec = en_cnt; run(16);
    chk("run_ticks", 16'(en_cnt - ec), 16'd4);

    // Single-cycle glitch must not pause
    sw.b = 1'b1; cycle(); sw.b = 1'b0;
    ec = en_cnt; run(8);
    chk("glitch_running", 16'(sw.running), 16'h1);
    chk("glitch_ticks", 16'(en_cnt - ec), 16'd2);

    // Pause holds the counter, mode change in pause reloads
    press_btn();
    ec = en_cnt; run(10);
    chk("pause_no_en", 16'(en_cnt - ec), 16'd0);
    sw.mode = 2'd2;
    lc = load_cnt; run(3);
    chk("m10_loads", 16'(load_cnt - lc), 16'd1);
    chk("m10_value", last_lv, 16'h9999);
    chk("m10_down", 16'(sw.cnt_up), 16'h0);

    // Mode change during run is ignored
    press_btn();
    sw.mode = 2'd0;
    run(6);
    chk("run_mode_ignored", 16'(sw.running), 16'h1);
    press_btn();
    run(4);
    press_btn();
    run(4);
    chk("resume_running", 16'(sw.running), 16'h1);
    chk("resume_down", 16'(sw.cnt_up), 16'h0);

    // Limit raised on a tick cycle
    begin
      int n;
      n = 0;
      while (!(ph == P_RUN && age % TD == TD - 1) && n < 40) begin cycle(); n++; end
      checks++;
      if (n >= 40) begin
        failures++;
        $error("FAIL tick_wait observed=%0d expected=<40", n);
      end
    end
    sw.cnt_at_lim = 1'b1; ec = en_cnt; cycle(); sw.cnt_at_lim = 1'b0;
    cycle();
    chk("lim_done", 16'(sw.done), 16'h1);
    chk("lim_no_en", 16'(en_cnt - ec), 16'd0);
    lc = load_cnt;
    press_btn();
    chk("done_reload", 16'(load_cnt - lc), 16'd1);
    chk("done_cleared", 16'(sw.done), 16'h0);

    // Out-of-range preset clamps; async reset in the middle of a run
    sw.mode = 2'd3; sw.MSB = 4'd12; sw.LSB = 4'd15;
    lc = load_cnt; run(3);
    chk("clamp_value", last_lv, 16'h9900);
    press_btn();
    run(6);
    chk("pre_reset_running", 16'(sw.running), 16'h1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("midrun");
    model_reset();
    sw.b = 1'b0; sw.mode = 2'd0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    lc = load_cnt; run(3);
    chk("post_reset_load", 16'(load_cnt - lc), 16'd1);
    chk("post_reset_value", last_lv, 16'h0000);

    // Start already at the limit: straight to done, no count enables
    sw.mode = 2'd3; sw.MSB = 4'd0; sw.LSB = 4'd0;
    run(3);
    chk("zero_preset_value", last_lv, 16'h0000);
    sw.cnt_at_lim = 1'b1;
    ec = en_cnt;
    press_btn();
    chk("atlim_done", 16'(sw.done), 16'h1);
    chk("atlim_no_en", 16'(en_cnt - ec), 16'd0);
    sw.cnt_at_lim = 1'b0;
    sw.mode = 2'd0;
    run(4);

    // Random traffic against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        sw.b = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 39) == 0) sw.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        sw.MSB = 4'($urandom_range(0, 15));
        sw.LSB = 4'($urandom_range(0, 15));
      end
      sw.cnt_at_lim = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
